// File: rtl/benes_pkg.sv
// Shared types and constants for the 8-port Benes routing path.
package benes_pkg;

  localparam int N = 8;
  localparam int W = 3;

  typedef logic [W-1:0] port_idx_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Index of the last entry processed before leaving RUN.
  localparam port_idx_t LAST_IDX = port_idx_t'(N - 1);

endpackage

// File: rtl/mn_serial_inverse.sv
// Serial inverse-permutation engine: captures MP and builds MN (mn[mp[i]] = i)
// one entry per clock, flagging duplicate destinations instead of publishing
// a corrupt inverse.
module mn_serial_inverse
  import benes_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] mp0,
  input  logic [W-1:0] mp1,
  input  logic [W-1:0] mp2,
  input  logic [W-1:0] mp3,
  input  logic [W-1:0] mp4,
  input  logic [W-1:0] mp5,
  input  logic [W-1:0] mp6,
  input  logic [W-1:0] mp7,
  output logic         busy,
  output logic         done,
  output logic         perm_err,
  output logic [W-1:0] mn0,
  output logic [W-1:0] mn1,
  output logic [W-1:0] mn2,
  output logic [W-1:0] mn3,
  output logic [W-1:0] mn4,
  output logic [W-1:0] mn5,
  output logic [W-1:0] mn6,
  output logic [W-1:0] mn7
);

  state_t    state;
  state_t    state_nxt;

  port_idx_t mp_in       [N];
  port_idx_t mp_lat      [N];
  port_idx_t scratch     [N];
  port_idx_t scratch_nxt [N];
  port_idx_t mn_reg      [N];
  logic [N-1:0] seen;
  logic      dup;
  logic      dup_nxt;
  port_idx_t idx;

  // Gather the flattened input entries into an indexable array.
  always_comb begin
    mp_in[0] = mp0;
    mp_in[1] = mp1;
    mp_in[2] = mp2;
    mp_in[3] = mp3;
    mp_in[4] = mp4;
    mp_in[5] = mp5;
    mp_in[6] = mp6;
    mp_in[7] = mp7;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic: one capture cycle, eight RUN cycles, one FIN cycle.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == LAST_IDX) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Scratch array and dup flag as they will look after this RUN step; the
  // last step publishes these directly so FIN already shows the full result.
  always_comb begin
    scratch_nxt = scratch;
    scratch_nxt[mp_lat[idx]] = idx;
    dup_nxt = dup | seen[mp_lat[idx]];
  end

  // Datapath: capture, serial scatter into scratch, and atomic publish of mn/perm_err.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: the small arrays are reset explicitly; an abandoned run must leave no stale working state.
      for (int j = 0; j < N; j++) begin
        mp_lat[j]  <= '0;
        scratch[j] <= '0;
        mn_reg[j]  <= port_idx_t'(j);
      end
      seen     <= '0;
      dup      <= 1'b0;
      idx      <= '0;
      perm_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            for (int j = 0; j < N; j++) begin
              mp_lat[j]  <= mp_in[j];
              scratch[j] <= '0;
            end
            seen <= '0;
            dup  <= 1'b0;
            idx  <= '0;
          end
        end
        RUN: begin
          scratch             <= scratch_nxt;
          seen[mp_lat[idx]]   <= 1'b1;
          dup                 <= dup_nxt;
          idx                 <= idx + port_idx_t'(1);
          if (idx == LAST_IDX) begin
            // All eight mn entries change on one edge, and only for a valid MP.
            if (!dup_nxt) mn_reg <= scratch_nxt;
            perm_err <= dup_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Status outputs decoded from state: busy through RUN, done for the single FIN cycle.
  always_comb begin
    busy = (state == RUN);
    done = (state == FIN);
  end

  assign mn0 = mn_reg[0];
  assign mn1 = mn_reg[1];
  assign mn2 = mn_reg[2];
  assign mn3 = mn_reg[3];
  assign mn4 = mn_reg[4];
  assign mn5 = mn_reg[5];
  assign mn6 = mn_reg[6];
  assign mn7 = mn_reg[7];

endmodule

// File: tb/tb_mn_serial_inverse.sv
// Self-checking bench for mn_serial_inverse: directed cases plus random
// permutations checked against a behavioural inverse model.
module tb_mn_serial_inverse;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       start = 1'b0;
  logic [23:0] mp_bus = '0;
  logic [2:0] mp0, mp1, mp2, mp3, mp4, mp5, mp6, mp7;
  logic [2:0] mn0, mn1, mn2, mn3, mn4, mn5, mn6, mn7;
  logic       busy, done, perm_err;
  logic [23:0] mn_bus;

  int errs = 0;
  int checks = 0;

  // Model state: last published inverse and error flag.
  logic [23:0] exp_mn;
  logic        exp_err;

  assign {mp7, mp6, mp5, mp4, mp3, mp2, mp1, mp0} = mp_bus;
  assign mn_bus = {mn7, mn6, mn5, mn4, mn3, mn2, mn1, mn0};

  always #5 clk = ~clk;

  mn_serial_inverse dut (
    .clk(clk), .rst(rst), .start(start),
    .mp0(mp0), .mp1(mp1), .mp2(mp2), .mp3(mp3),
    .mp4(mp4), .mp5(mp5), .mp6(mp6), .mp7(mp7),
    .busy(busy), .done(done), .perm_err(perm_err),
    .mn0(mn0), .mn1(mn1), .mn2(mn2), .mn3(mn3),
    .mn4(mn4), .mn5(mn5), .mn6(mn6), .mn7(mn7)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] pack8(input int a0, a1, a2, a3, a4, a5, a6, a7);
    logic [23:0] v;
    v = '0;
    v[2:0]   = 3'(a0); v[5:3]   = 3'(a1); v[8:6]   = 3'(a2); v[11:9]  = 3'(a3);
    v[14:12] = 3'(a4); v[17:15] = 3'(a5); v[20:18] = 3'(a6); v[23:21] = 3'(a7);
    return v;
  endfunction

  // Reference: an MP is valid iff every destination is hit exactly once; the
  // inverse maps each destination back to its source. Invalid MP keeps old mn.
  task automatic model_apply(input logic [23:0] mpv);
    int hits [8];
    int dest;
    bit bad;
    logic [23:0] inv;
    for (int d = 0; d < 8; d++) hits[d] = 0;
    inv = '0;
    for (int i = 0; i < 8; i++) begin
      dest = int'(mpv[3*i +: 3]);
      hits[dest]++;
      inv[3*dest +: 3] = 3'(i);
    end
    bad = 1'b0;
    for (int d = 0; d < 8; d++) if (hits[d] != 1) bad = 1'b1;
    exp_err = bad;
    if (!bad) exp_mn = inv;
  endtask

  // One inversion from IDLE. With perturb set, start is held high and mp is
  // scrambled for the whole run, including the done cycle.
  task automatic run_inv(input string tag, input logic [23:0] mpv, input bit perturb);
    int n;
    int busy_low;
    @(negedge clk);
    mp_bus = mpv;
    start  = 1'b1;
    model_apply(mpv);
    @(negedge clk);                       // capture edge has passed
    if (!perturb) start = 1'b0;
    n = 1;
    busy_low = 0;
    while (!done && n < 20) begin
      if (!busy) busy_low++;
      if (perturb) mp_bus = 24'($urandom);
      @(negedge clk);
      n++;
    end
    // done is visible after the 9th edge following start, sampled by the 10th.
    check({tag, "_latency"}, 32'(n), 32'd9);
    check({tag, "_busy_run"}, 32'(busy_low), 32'd0);
    check({tag, "_busy_fin"}, {31'd0, busy}, 32'd0);
    check({tag, "_mn"}, {8'd0, mn_bus}, {8'd0, exp_mn});
    check({tag, "_err"}, {31'd0, perm_err}, {31'd0, exp_err});
    @(negedge clk);                       // FIN -> IDLE edge; start here is ignored
    start = 1'b0;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    logic [23:0] ident;
    logic [23:0] rand_mp;
    int perm [8];
    int j, tmp;

    ident   = pack8(0, 1, 2, 3, 4, 5, 6, 7);
    exp_mn  = ident;
    exp_err = 1'b0;

    // Reset state.
    rst = 1'b1;
    #12;
    check("rst_mn", {8'd0, mn_bus}, {8'd0, ident});
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_err", {31'd0, perm_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed example with a hand-derived inverse.
    run_inv("ex", pack8(6, 2, 5, 4, 0, 7, 1, 3), 1'b0);
    check("ex_const", {8'd0, mn_bus}, {8'd0, pack8(4, 6, 1, 7, 3, 2, 0, 5)});

    // Identity and reversal.
    run_inv("ident", ident, 1'b0);
    run_inv("rev", pack8(7, 6, 5, 4, 3, 2, 1, 0), 1'b0);
    check("rev_const", {8'd0, mn_bus}, {8'd0, pack8(7, 6, 5, 4, 3, 2, 1, 0)});

    // Duplicate destination: error flagged, reversal inverse kept.
    run_inv("dup", pack8(1, 1, 2, 3, 4, 5, 6, 7), 1'b0);
    check("dup_err_const", {31'd0, perm_err}, 32'd1);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    mp_bus = pack8(3, 0, 1, 2, 7, 4, 5, 6);
    start  = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_mn", {8'd0, mn_bus}, {8'd0, ident});
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_err", {31'd0, perm_err}, 32'd0);
    exp_mn  = ident;
    exp_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    // No done pulse from the abandoned run.
    repeat (10) @(negedge clk);
    check("mid_rst_no_done", {31'd0, done}, 32'd0);

    // start held and mp scrambled during the run: only the captured mp counts.
    run_inv("perturb", pack8(5, 3, 7, 0, 2, 6, 4, 1), 1'b1);

    // Random valid permutations (Fisher-Yates).
    for (int t = 0; t < 100; t++) begin
      for (int i = 0; i < 8; i++) perm[i] = i;
      for (int i = 7; i > 0; i--) begin
        j = int'($urandom_range(i, 0));
        tmp = perm[i]; perm[i] = perm[j]; perm[j] = tmp;
      end
      rand_mp = pack8(perm[0], perm[1], perm[2], perm[3], perm[4], perm[5], perm[6], perm[7]);
      run_inv("rnd", rand_mp, 1'b0);
    end

    // A few random (mostly invalid) entry sets.
    for (int t = 0; t < 5; t++) begin
      rand_mp = 24'($urandom);
      run_inv("rnd_any", rand_mp, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
